// File: rtl/uart_pkg.sv
// uart_pkg: state encodings shared by the TX and RX FSMs of uart_cfg, plus
// the parity helper used on both the transmit and the receive path.
//   ST_IDLE .. ST_STOP : 3-bit FSM state codes
//   parity_of()        : XOR-reduce of a zero-extended payload, optionally inverted
package uart_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    // Payloads narrower than 9 bits are zero-extended by the caller; the
    // extra zeros do not change the XOR.
    function automatic logic parity_of(input logic [8:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: baud counter for one direction of the UART.
//   clk, rst : clock, asynchronous active-high reset
//   restart  : hold the counter at zero (used while the owning FSM is idle)
//   half     : count a half bit period instead of a full one
//   tick     : high for one cycle at the end of the current period
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    input  logic half,
    output logic tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Terminal-count decode and wrap at CLKS_PER_BIT-1 rather than 2^n.
    always_comb begin
        tick = 1'b0;
        if (restart) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (cnt_q == (half ? HALF_LAST : FULL_LAST)) begin
            tick  = 1'b1;
            cnt_d = {CNT_W{1'b0}};
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_cfg.sv
// uart_cfg: parametrised full-duplex UART.
//   clk, rst           : clock, asynchronous active-high reset
//   tx_data/tx_valid   : frame to send, accepted when tx_valid && tx_ready
//   tx_ready           : TX idle (or on its last stop cycle) and able to accept
//   tx                 : serial output, idle high
//   rx                 : serial input, asynchronous to clk
//   rx_data            : last received payload, held until the next rx_valid
//   rx_valid           : one-cycle strobe at the stop-bit centre
//   rx_parity_err      : parity mismatch, qualified by rx_valid
//   rx_frame_err       : stop bit sampled low, qualified by rx_valid
module uart_cfg
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err
);

    localparam int BCNT_W = $clog2(DATA_BITS + 1);
    localparam logic [BCNT_W-1:0] LAST_DATA = BCNT_W'(DATA_BITS - 1);
    localparam logic [BCNT_W-1:0] LAST_STOP = BCNT_W'(STOP_BITS - 1);
    localparam logic PAR_EN  = (PARITY_EN != 0);
    localparam logic PAR_ODD = (PARITY_ODD != 0);

    // ---------------- TX ----------------
    logic [2:0]           tx_state_q, tx_state_d;
    logic                 tx_q, tx_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic [BCNT_W-1:0]    tx_bit_q, tx_bit_d;
    logic                 tx_par_q, tx_par_d;
    logic                 tx_tick, tx_restart, tx_last_stop, tx_ready_s, tx_accept;

    assign tx_restart = (tx_state_q == ST_IDLE);

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_timer (
        .clk     (clk),
        .rst     (rst),
        .restart (tx_restart),
        .half    (1'b0),
        .tick    (tx_tick)
    );

    // TX next state. tx_ready is decoded from registered state so it can rise
    // on the last stop cycle and let a new frame follow with no idle gap.
    // The stop-bit count reuses the data bit counter.
    always_comb begin
        tx_state_d   = tx_state_q;
        tx_d         = tx_q;
        tx_shift_d   = tx_shift_q;
        tx_bit_d     = tx_bit_q;
        tx_par_d     = tx_par_q;
        tx_last_stop = (tx_state_q == ST_STOP) && (tx_bit_q == LAST_STOP) && tx_tick;
        tx_ready_s   = (tx_state_q == ST_IDLE) || tx_last_stop;
        tx_accept    = tx_valid && tx_ready_s;
        case (tx_state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
            end
            ST_START: begin
                if (tx_tick) begin
                    tx_d       = tx_shift_q[0];
                    tx_bit_d   = {BCNT_W{1'b0}};
                    tx_state_d = ST_DATA;
                end else begin
                    tx_d = 1'b0;
                end
            end
            ST_DATA: begin
                if (tx_tick) begin
                    if (tx_bit_q == LAST_DATA) begin
                        tx_bit_d = {BCNT_W{1'b0}};
                        if (PAR_EN) begin
                            tx_state_d = ST_PARITY;
                            tx_d       = tx_par_q;
                        end else begin
                            tx_state_d = ST_STOP;
                            tx_d       = 1'b1;
                        end
                    end else begin
                        tx_d       = tx_shift_q[1];
                        tx_shift_d = tx_shift_q >> 1;
                        tx_bit_d   = tx_bit_q + BCNT_W'(1);
                    end
                end else begin
                    tx_d = tx_q;
                end
            end
            ST_PARITY: begin
                if (tx_tick) begin
                    tx_state_d = ST_STOP;
                    tx_d       = 1'b1;
                end else begin
                    tx_d = tx_q;
                end
            end
            ST_STOP: begin
                if (tx_tick) begin
                    if (tx_bit_q == LAST_STOP) begin
                        tx_state_d = ST_IDLE;
                    end else begin
                        tx_bit_d = tx_bit_q + BCNT_W'(1);
                    end
                end else begin
                    tx_d = 1'b1;
                end
            end
            default: begin
                tx_state_d = ST_IDLE;
                tx_d       = 1'b1;
            end
        endcase
        if (tx_accept) begin
            tx_state_d = ST_START;
            tx_d       = 1'b0;
            tx_shift_d = tx_data;
            tx_par_d   = parity_of(9'(tx_data), PAR_ODD);
        end else begin
            tx_par_d = tx_par_q;
        end
    end

    // TX registers; tx idles high, also straight out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q <= ST_IDLE;
            tx_q       <= 1'b1;
            tx_shift_q <= {DATA_BITS{1'b0}};
            tx_bit_q   <= {BCNT_W{1'b0}};
            tx_par_q   <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_q       <= tx_d;
            tx_shift_q <= tx_shift_d;
            tx_bit_q   <= tx_bit_d;
            tx_par_q   <= tx_par_d;
        end
    end

    assign tx       = tx_q;
    assign tx_ready = tx_ready_s;

    // ---------------- RX ----------------
    logic [1:0]           rx_sync_q;
    logic                 rx_s;
    logic [2:0]           rx_state_q, rx_state_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic [BCNT_W-1:0]    rx_bit_q, rx_bit_d;
    logic                 rx_perr_acc_q, rx_perr_acc_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 rx_perr_q, rx_perr_d;
    logic                 rx_ferr_q, rx_ferr_d;
    logic                 rx_tick, rx_restart, rx_half;

    assign rx_s       = rx_sync_q[1];
    assign rx_restart = (rx_state_q == ST_IDLE);
    assign rx_half    = (rx_state_q == ST_START);

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_timer (
        .clk     (clk),
        .rst     (rst),
        .restart (rx_restart),
        .half    (rx_half),
        .tick    (rx_tick)
    );

    // RX next state: half period into START to find the bit centre, then a
    // full period per bit. Leaving STOP straight to IDLE lets a held-low line
    // restart a frame at once.
    always_comb begin
        rx_state_d    = rx_state_q;
        rx_shift_d    = rx_shift_q;
        rx_bit_d      = rx_bit_q;
        rx_perr_acc_d = rx_perr_acc_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = 1'b0;
        rx_perr_d     = rx_perr_q;
        rx_ferr_d     = rx_ferr_q;
        case (rx_state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    rx_state_d    = ST_START;
                    rx_perr_acc_d = 1'b0;
                end else begin
                    rx_state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (rx_tick) begin
                    if (rx_s) begin
                        rx_state_d = ST_IDLE;
                    end else begin
                        rx_state_d = ST_DATA;
                        rx_bit_d   = {BCNT_W{1'b0}};
                    end
                end else begin
                    rx_state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (rx_tick) begin
                    rx_shift_d = {rx_s, rx_shift_q[DATA_BITS-1:1]};
                    if (rx_bit_q == LAST_DATA) begin
                        rx_bit_d   = {BCNT_W{1'b0}};
                        rx_state_d = PAR_EN ? ST_PARITY : ST_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + BCNT_W'(1);
                    end
                end else begin
                    rx_state_d = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (rx_tick) begin
                    rx_perr_acc_d = (rx_s != parity_of(9'(rx_shift_q), PAR_ODD));
                    rx_state_d    = ST_STOP;
                end else begin
                    rx_state_d = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (rx_tick) begin
                    rx_data_d  = rx_shift_q;
                    rx_valid_d = 1'b1;
                    rx_ferr_d  = !rx_s;
                    rx_perr_d  = PAR_EN ? rx_perr_acc_q : 1'b0;
                    rx_state_d = ST_IDLE;
                end else begin
                    rx_state_d = ST_STOP;
                end
            end
            default: begin
                rx_state_d = ST_IDLE;
            end
        endcase
    end

    // RX registers, including the 2-flop synchroniser that idles high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_sync_q     <= 2'b11;
            rx_state_q    <= ST_IDLE;
            rx_shift_q    <= {DATA_BITS{1'b0}};
            rx_bit_q      <= {BCNT_W{1'b0}};
            rx_perr_acc_q <= 1'b0;
            rx_data_q     <= {DATA_BITS{1'b0}};
            rx_valid_q    <= 1'b0;
            rx_perr_q     <= 1'b0;
            rx_ferr_q     <= 1'b0;
        end else begin
            rx_sync_q     <= {rx_sync_q[0], rx};
            rx_state_q    <= rx_state_d;
            rx_shift_q    <= rx_shift_d;
            rx_bit_q      <= rx_bit_d;
            rx_perr_acc_q <= rx_perr_acc_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            rx_perr_q     <= rx_perr_d;
            rx_ferr_q     <= rx_ferr_d;
        end
    end

    assign rx_data       = rx_data_q;
    assign rx_valid      = rx_valid_q;
    assign rx_parity_err = rx_perr_q;
    assign rx_frame_err  = rx_ferr_q;

endmodule

// File: tb/tb_uart_cfg.sv
// Bench for uart_cfg: three instances (8N1, 8 bits odd parity, 5 bits 2 stop)
// all at 4 clocks per bit, checked against a frame-level model.
module tb_uart_cfg;

    localparam int CPB = 4;
    localparam int NB  [3] = '{8, 8, 5};
    localparam int PEN [3] = '{0, 1, 0};
    localparam int ODD [3] = '{0, 1, 0};
    localparam int NST [3] = '{1, 1, 2};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [8:0] txd [3];
    logic       txv [3];
    logic       txr [3];
    logic       txo [3];
    logic       rxi [3];
    logic       rx_drv [3];
    logic       loop [3];
    logic [8:0] rxd [3];
    logic       rxv [3];
    logic       rxpe [3];
    logic       rxfe [3];
    logic [7:0] rxd0, rxd1;
    logic [4:0] rxd2;

    assign rxd[0] = {1'b0, rxd0};
    assign rxd[1] = {1'b0, rxd1};
    assign rxd[2] = {4'b0000, rxd2};
    assign rxi[0] = loop[0] ? txo[0] : rx_drv[0];
    assign rxi[1] = loop[1] ? txo[1] : rx_drv[1];
    assign rxi[2] = loop[2] ? txo[2] : rx_drv[2];

    uart_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rst(rst), .tx_data(txd[0][7:0]), .tx_valid(txv[0]), .tx_ready(txr[0]),
        .tx(txo[0]), .rx(rxi[0]), .rx_data(rxd0), .rx_valid(rxv[0]),
        .rx_parity_err(rxpe[0]), .rx_frame_err(rxfe[0]));

    uart_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u1 (
        .clk(clk), .rst(rst), .tx_data(txd[1][7:0]), .tx_valid(txv[1]), .tx_ready(txr[1]),
        .tx(txo[1]), .rx(rxi[1]), .rx_data(rxd1), .rx_valid(rxv[1]),
        .rx_parity_err(rxpe[1]), .rx_frame_err(rxfe[1]));

    uart_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(5), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u2 (
        .clk(clk), .rst(rst), .tx_data(txd[2][4:0]), .tx_valid(txv[2]), .tx_ready(txr[2]),
        .tx(txo[2]), .rx(rxi[2]), .rx_data(rxd2), .rx_valid(rxv[2]),
        .rx_parity_err(rxpe[2]), .rx_frame_err(rxfe[2]));

    // ---------------- reference model ----------------
    function automatic logic [8:0] mask(input int k);
        logic [8:0] m;
        m = 9'h000;
        for (int i = 0; i < NB[k]; i++) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic exp_par(input int k, input logic [8:0] d);
        int ones;
        ones = 0;
        for (int i = 0; i < NB[k]; i++) ones += int'(d[i]);
        return 1'((ones % 2) ^ ODD[k]);
    endfunction

    function automatic int frame_len(input int k);
        return 1 + NB[k] + PEN[k] + NST[k];
    endfunction

    // Line level during bit period idx of a frame carrying d.
    function automatic logic frame_bit(input int k, input logic [8:0] d, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= NB[k]) return d[idx-1];
        if (PEN[k] != 0 && idx == NB[k] + 1) return exp_par(k, d);
        return 1'b1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        for (int pass = 0; pass < 2; pass++) begin
            for (int k = 0; k < 3; k++) begin
                total++;
                if (txo[k] !== 1'b1 || txr[k] !== 1'b1) begin
                    bad++;
                    $display("FAIL reset_tx k=%0d tx=%b ready=%b want 1/1", k, txo[k], txr[k]);
                end
                total++;
                if (rxv[k] !== 1'b0 || rxd[k] !== 9'h000 || rxpe[k] !== 1'b0 || rxfe[k] !== 1'b0) begin
                    bad++;
                    $display("FAIL reset_rx k=%0d valid=%b data=%h pe=%b fe=%b want all 0",
                             k, rxv[k], rxd[k], rxpe[k], rxfe[k]);
                end
            end
            rst = 1'b0;
            tick();
        end
    endtask

    // Sends one frame and checks every cycle of the line and of tx_ready.
    // Junk tx_valid/tx_data while busy must be ignored.
    task automatic test_tx(input int k, input logic [8:0] d_in);
        logic [8:0] d;
        int L;
        d = d_in & mask(k);
        total++;
        if (txr[k] !== 1'b1) begin
            bad++;
            $display("FAIL tx_idle_ready k=%0d got=%b want=1", k, txr[k]);
        end
        txd[k] = d;
        txv[k] = 1'b1;
        tick();
        L = frame_len(k) * CPB;
        for (int i = 0; i < L; i++) begin
            if (i < L - 2) begin
                txv[k] = 1'b1;
                txd[k] = 9'($urandom);
            end else begin
                txv[k] = 1'b0;
            end
            total++;
            if (txo[k] !== frame_bit(k, d, i / CPB)) begin
                bad++;
                $display("FAIL tx_line k=%0d data=%h cyc=%0d got=%b want=%b",
                         k, d, i + 1, txo[k], frame_bit(k, d, i / CPB));
            end
            total++;
            if (txr[k] !== 1'(i == L - 1)) begin
                bad++;
                $display("FAIL tx_ready k=%0d cyc=%0d got=%b want=%b", k, i + 1, txr[k], i == L - 1);
            end
            tick();
        end
        txv[k] = 1'b0;
    endtask

    // Drives one frame into rx and checks the single resulting strobe.
    task automatic test_rx(input int k, input logic [8:0] d_in, input logic par_bit,
                           input logic stop_bit, input string name);
        logic [8:0] d, cap_d;
        logic cap_pe, cap_fe, want_pe;
        int nstr, nb;
        d = d_in & mask(k);
        nstr = 0;
        cap_d = 9'h000; cap_pe = 1'b0; cap_fe = 1'b0;
        nb = 1 + NB[k] + PEN[k] + 1;
        want_pe = (PEN[k] != 0) && (par_bit != exp_par(k, d));
        for (int b = 0; b < nb + 3; b++) begin
            if (b == 0) rx_drv[k] = 1'b0;
            else if (b <= NB[k]) rx_drv[k] = d[b-1];
            else if (PEN[k] != 0 && b == NB[k] + 1) rx_drv[k] = par_bit;
            else if (b == nb - 1) rx_drv[k] = stop_bit;
            else rx_drv[k] = 1'b1;
            for (int c = 0; c < CPB; c++) begin
                tick();
                if (rxv[k] === 1'b1) begin
                    nstr++;
                    cap_d = rxd[k]; cap_pe = rxpe[k]; cap_fe = rxfe[k];
                end
            end
        end
        total++;
        if (nstr != 1) begin
            bad++;
            $display("FAIL %s_strobes k=%0d got=%0d want=1", name, k, nstr);
        end
        total++;
        if (cap_d !== d) begin
            bad++;
            $display("FAIL %s_data k=%0d got=%h want=%h", name, k, cap_d, d);
        end
        total++;
        if (cap_pe !== want_pe || cap_fe !== !stop_bit) begin
            bad++;
            $display("FAIL %s_flags k=%0d pe=%b fe=%b want pe=%b fe=%b",
                     name, k, cap_pe, cap_fe, want_pe, !stop_bit);
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] frames [5];
        logic [8:0] exp_q [$];
        logic [8:0] w;
        logic acc;
        int sent, got, last_acc;
        frames[0] = 9'h000; frames[1] = 9'h0FF; frames[2] = 9'h03C;
        frames[3] = 9'($urandom) & 9'h0FF; frames[4] = 9'($urandom) & 9'h0FF;
        sent = 0; got = 0; last_acc = 0;
        loop[0] = 1'b1;
        txd[0] = frames[0];
        txv[0] = 1'b1;
        for (int cyc = 0; cyc < 5 * 40 + 100 && got < 5; cyc++) begin
            acc = (txv[0] === 1'b1) && (txr[0] === 1'b1);
            if (rxv[0] === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL b2b_extra_strobe data=%h want none", rxd[0]);
                end else begin
                    w = exp_q.pop_front();
                    got++;
                    if (rxd[0] !== w || rxpe[0] !== 1'b0 || rxfe[0] !== 1'b0) begin
                        bad++;
                        $display("FAIL b2b_rx data=%h pe=%b fe=%b want %h/0/0", rxd[0], rxpe[0], rxfe[0], w);
                    end
                end
            end
            tick();
            if (acc) begin
                exp_q.push_back(txd[0]);
                total++;
                if (txo[0] !== 1'b0 || txr[0] !== 1'b0) begin
                    bad++;
                    $display("FAIL b2b_start frame=%0d tx=%b ready=%b want 0/0", sent, txo[0], txr[0]);
                end
                if (sent > 0) begin
                    total++;
                    if (cyc - last_acc != 40) begin
                        bad++;
                        $display("FAIL b2b_spacing frame=%0d got=%0d want=40", sent, cyc - last_acc);
                    end
                end
                last_acc = cyc;
                sent++;
                if (sent < 5) txd[0] = frames[sent];
                else txv[0] = 1'b0;
            end
        end
        txv[0] = 1'b0;
        total++;
        if (got != 5) begin
            bad++;
            $display("FAIL b2b_count got=%0d want=5", got);
        end
        loop[0] = 1'b0;
        repeat (2 * CPB) tick();
    endtask

    task automatic test_glitch();
        int nstr;
        nstr = 0;
        rx_drv[0] = 1'b0;
        tick();
        rx_drv[0] = 1'b1;
        for (int c = 0; c < 4 * CPB; c++) begin
            tick();
            if (rxv[0] === 1'b1) nstr++;
        end
        total++;
        if (nstr != 0) begin
            bad++;
            $display("FAIL glitch_strobes got=%0d want=0", nstr);
        end
        test_rx(0, 9'h05A, 1'b0, 1'b1, "post_glitch");
    endtask

    task automatic test_reset_mid();
        int nstr;
        nstr = 0;
        loop[0] = 1'b1;
        txd[0] = 9'h0C3;
        txv[0] = 1'b1;
        tick();
        txv[0] = 1'b0;
        repeat (14) tick();
        #3;
        rst = 1'b1;
        #1;
        total++;
        if (txo[0] !== 1'b1 || txr[0] !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_async tx=%b ready=%b want 1/1", txo[0], txr[0]);
        end
        tick();
        tick();
        rst = 1'b0;
        for (int c = 0; c < 12 * CPB; c++) begin
            if (rxv[0] === 1'b1) nstr++;
            tick();
        end
        total++;
        if (nstr != 0 || rxd[0] !== 9'h000) begin
            bad++;
            $display("FAIL rst_mid_rx strobes=%0d data=%h want 0/00", nstr, rxd[0]);
        end
        loop[0] = 1'b0;
        test_rx(0, 9'h081, 1'b0, 1'b1, "after_rst");
    endtask

    initial begin
        logic [8:0] r;
        for (int k = 0; k < 3; k++) begin
            txv[k] = 1'b0; txd[k] = 9'h000; rx_drv[k] = 1'b1; loop[k] = 1'b0;
        end
        test_reset();
        test_tx(0, 9'h0A5);
        test_tx(0, 9'($urandom));
        test_tx(1, 9'($urandom));
        test_tx(2, 9'h01F);
        test_tx(2, 9'($urandom));
        test_back_to_back();
        test_rx(1, 9'h007, 1'b1, 1'b1, "par_bad");
        test_rx(1, 9'h007, 1'b0, 1'b1, "par_good");
        for (int n = 0; n < 3; n++) begin
            r = 9'($urandom) & 9'h0FF;
            test_rx(1, r, exp_par(1, r), 1'b1, "par_rand_ok");
            test_rx(1, r, !exp_par(1, r), 1'b1, "par_rand_bad");
            test_rx(2, 9'($urandom), 1'b0, 1'b1, "rx5_rand");
        end
        test_glitch();
        test_rx(0, 9'h055, 1'b0, 1'b0, "frame_err");
        test_rx(0, 9'($urandom), 1'b0, 1'b1, "post_frame_err");
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
